// File: rtl/usb_rx_pkg.sv
// rtl/usb_rx_pkg.sv - shared types and constants for the USB full-speed receive path
package usb_rx_pkg;

    localparam logic [7:0] SYNC_BYTE_DEFAULT      = 8'h80;
    localparam int         MAX_DATA_BYTES_DEFAULT = 64;

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;

    typedef enum logic [2:0] {
        RX_NONE  = 3'd0,
        RX_OUT   = 3'd1,
        RX_IN    = 3'd2,
        RX_DATA0 = 3'd3,
        RX_DATA1 = 3'd4,
        RX_ACK   = 3'd5,
        RX_NAK   = 3'd6,
        RX_OTHER = 3'd7
    } rx_packet_t;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SYNC_WAIT,
        ST_PID_WAIT,
        ST_TOKEN_SKIP,
        ST_DATA_RX,
        ST_EOP_WAIT,
        ST_DONE,
        ST_ERR_EOP,
        ST_ERR_IDLE
    } rcu_state_t;

endpackage

// File: rtl/usb_pid_decode.sv
// rtl/usb_pid_decode.sv - combinational PID byte check and class decode
module usb_pid_decode
    import usb_rx_pkg::*;
(
    input  logic [7:0] pid_byte,
    output logic       valid,
    output rx_packet_t packet
);

    always_comb begin
        valid  = (pid_byte[7:4] == ~pid_byte[3:0]);
        packet = RX_NONE;
        if (valid) begin
            unique case (pid_byte[3:0])
                PID_OUT:   packet = RX_OUT;
                PID_IN:    packet = RX_IN;
                PID_DATA0: packet = RX_DATA0;
                PID_DATA1: packet = RX_DATA1;
                PID_ACK:   packet = RX_ACK;
                PID_NAK:   packet = RX_NAK;
                default:   packet = RX_OTHER;
            endcase
        end
    end

endmodule

// File: rtl/usb_rx_rcu.sv
// rtl/usb_rx_rcu.sv - USB RX control unit: SYNC/PID check, data steering, error reporting
module usb_rx_rcu
    import usb_rx_pkg::*;
#(
    parameter int         MAX_DATA_BYTES = MAX_DATA_BYTES_DEFAULT,
    parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       d_edge,
    input  logic       eop,
    input  logic       shift_enable,
    input  logic       byte_received,
    input  logic [7:0] rcv_data,
    input  logic       fifo_full,
    output logic       idle,
    output logic       rcving,
    output logic       w_enable,
    output logic       r_error,
    output rx_packet_t rx_packet,
    output logic       rx_data_ready
);

    localparam int             CW      = $clog2(MAX_DATA_BYTES + 1);
    localparam logic [CW-1:0]  MAX_CNT = CW'(MAX_DATA_BYTES);

    rcu_state_t    state, state_next;
    logic [CW-1:0] count, count_next;
    logic          byte_received_q;
    logic          byte_evt, eop_evt;
    logic          wr, pkt_load, err_clr;
    logic          pid_valid;
    rx_packet_t    pid_packet;

    assign byte_evt = byte_received & ~byte_received_q;
    assign eop_evt  = eop & shift_enable;

    usb_pid_decode u_pid_decode (
        .pid_byte (rcv_data),
        .valid    (pid_valid),
        .packet   (pid_packet)
    );

    always_comb begin
        state_next = state;
        count_next = count;
        wr         = 1'b0;
        pkt_load   = 1'b0;
        err_clr    = 1'b0;

        // First pass: byte arrival and line edges.
        case (state)
            ST_IDLE, ST_ERR_IDLE: begin
                if (d_edge) begin
                    state_next = ST_SYNC_WAIT;
                    err_clr    = 1'b1;
                end
            end
            ST_SYNC_WAIT: begin
                if (byte_evt)
                    state_next = (rcv_data == SYNC_BYTE) ? ST_PID_WAIT : ST_ERR_EOP;
            end
            ST_PID_WAIT: begin
                if (byte_evt) begin
                    state_next = ST_ERR_EOP;
                    if (pid_valid) begin
                        pkt_load = 1'b1;
                        case (rcv_data[3:0])
                            PID_OUT, PID_IN: begin
                                state_next = ST_TOKEN_SKIP;
                                count_next = '0;
                            end
                            PID_ACK, PID_NAK, PID_STALL: state_next = ST_EOP_WAIT;
                            PID_DATA0, PID_DATA1: begin
                                state_next = ST_DATA_RX;
                                count_next = '0;
                            end
                            default: state_next = ST_ERR_EOP;
                        endcase
                    end
                end
            end
            ST_TOKEN_SKIP: begin
                if (byte_evt) begin
                    if (count == CW'(1)) begin
                        state_next = ST_EOP_WAIT;
                        count_next = '0;
                    end else begin
                        count_next = count + CW'(1);
                    end
                end
            end
            ST_DATA_RX: begin
                if (byte_evt) begin
                    if (fifo_full || count == MAX_CNT) begin
                        state_next = ST_ERR_EOP;
                    end else begin
                        wr         = 1'b1;
                        count_next = count + CW'(1);
                    end
                end
            end
            ST_EOP_WAIT: begin
                if (byte_evt)
                    state_next = ST_ERR_EOP;
            end
            ST_DONE: begin
                if (d_edge && !eop)
                    state_next = ST_IDLE;
            end
            default: state_next = state;
        endcase

        // Second pass: EOP judged against the post-byte state and count.
        if (eop_evt && !(state inside {ST_IDLE, ST_ERR_IDLE, ST_DONE})) begin
            case (state_next)
                ST_SYNC_WAIT, ST_PID_WAIT, ST_TOKEN_SKIP: state_next = ST_ERR_IDLE;
                ST_DATA_RX:  state_next = (count_next >= CW'(2)) ? ST_DONE : ST_ERR_IDLE;
                ST_EOP_WAIT: state_next = ST_DONE;
                ST_ERR_EOP:  state_next = ST_ERR_IDLE;
                default:     state_next = state_next;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= ST_IDLE;
            count           <= '0;
            byte_received_q <= 1'b0;
            idle            <= 1'b1;
            rcving          <= 1'b0;
            w_enable        <= 1'b0;
            r_error         <= 1'b0;
            rx_packet       <= RX_NONE;
            rx_data_ready   <= 1'b0;
        end else begin
            state           <= state_next;
            count           <= count_next;
            byte_received_q <= byte_received;
            w_enable        <= wr;
            rx_data_ready   <= (state == ST_DATA_RX) && (state_next == ST_DONE);
            idle            <= (state_next inside {ST_IDLE, ST_ERR_IDLE});
            rcving          <= !(state_next inside {ST_IDLE, ST_ERR_IDLE});
            if (err_clr)
                r_error <= 1'b0;
            else if (state_next inside {ST_ERR_EOP, ST_ERR_IDLE})
                r_error <= 1'b1;
            if (pkt_load)
                rx_packet <= pid_packet;
        end
    end

endmodule

// File: tb/tb_usb_rx_rcu.sv
// tb/tb_usb_rx_rcu.sv - randomized self-checking bench for usb_rx_rcu with packet-level model
module tb_usb_rx_rcu;
    import usb_rx_pkg::*;

    logic       clk = 1'b0;
    logic       rst, d_edge, eop, shift_enable, byte_received, fifo_full;
    logic [7:0] rcv_data;
    logic       idle, rcving, w_enable, r_error, rx_data_ready;
    rx_packet_t rx_packet;

    always #5 clk = ~clk;

    usb_rx_rcu dut (
        .clk           (clk),
        .rst           (rst),
        .d_edge        (d_edge),
        .eop           (eop),
        .shift_enable  (shift_enable),
        .byte_received (byte_received),
        .rcv_data      (rcv_data),
        .fifo_full     (fifo_full),
        .idle          (idle),
        .rcving        (rcving),
        .w_enable      (w_enable),
        .r_error       (r_error),
        .rx_packet     (rx_packet),
        .rx_data_ready (rx_data_ready)
    );

    int tests_run    = 0;
    int tests_failed = 0;
    int pkt_prev     = 0;

    logic [7:0] wr_q[$];
    int         ready_cnt = 0;

    always @(negedge clk) begin
        if (w_enable === 1'b1)      wr_q.push_back(rcv_data);
        if (rx_data_ready === 1'b1) ready_cnt++;
    end

    task automatic check(input string tag, input int got, input int exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int pid_class(input logic [3:0] t);
        case (t)
            4'b0001: return 1;
            4'b1001: return 2;
            4'b0011: return 3;
            4'b1011: return 4;
            4'b0010: return 5;
            4'b1010: return 6;
            default: return 7;
        endcase
    endfunction

    task automatic send_byte(input logic [7:0] b, input int hold, input logic full);
        rcv_data      = b;
        fifo_full     = full;
        byte_received = 1'b1;
        repeat (hold) tick;
        byte_received = 1'b0;
        fifo_full     = 1'b0;
        repeat ($urandom_range(1, 3)) begin
            d_edge = ($urandom_range(0, 3) == 0);
            tick;
        end
        d_edge = 1'b0;
    endtask

    task automatic start_packet;
        d_edge = 1'b1;
        tick;
        d_edge = 1'b0;
        tick;
    endtask

    task automatic run_packet(input logic [7:0] bytes[$], input int full_idx,
                              input int hold_lo, input int hold_hi);
        logic [7:0] exp_w[$];
        logic [7:0] pid;
        int err, ready, n, base, rbase;

        // Packet-level expectation from the framing rules.
        err = 0; ready = 0; n = bytes.size();
        if (n < 2 || bytes[0] != 8'h80) begin
            err = 1;
        end else begin
            pid = bytes[1];
            if (pid[7:4] !== ~pid[3:0]) begin
                err = 1;
            end else begin
                pkt_prev = pid_class(pid[3:0]);
                case (pid[3:0])
                    4'b0001, 4'b1001:          err = (n != 4);
                    4'b0010, 4'b1010, 4'b1110: err = (n != 2);
                    4'b0011, 4'b1011: begin
                        for (int i = 2; i < n; i++) begin
                            if (i - 2 == full_idx || i - 2 >= 64) begin
                                err = 1;
                                break;
                            end
                            exp_w.push_back(bytes[i]);
                        end
                        if (!err && n - 2 < 2) err = 1;
                        ready = !err;
                    end
                    default: err = 1;
                endcase
            end
        end

        base  = wr_q.size();
        rbase = ready_cnt;
        start_packet;
        check("start_rcving", int'(rcving), 1);
        check("start_idle", int'(idle), 0);
        check("start_r_error", int'(r_error), 0);
        foreach (bytes[i])
            send_byte(bytes[i], $urandom_range(hold_lo, hold_hi), (i >= 2) && (i - 2 == full_idx));

        eop = 1'b1;
        tick;
        shift_enable = 1'b1;
        tick;
        shift_enable = 1'b0;
        tick;
        tick;
        check("wr_count", wr_q.size() - base, exp_w.size());
        for (int i = 0; i < exp_w.size() && base + i < wr_q.size(); i++)
            check("wr_data", int'(wr_q[base + i]), int'(exp_w[i]));
        check("data_ready", ready_cnt - rbase, ready);
        check("r_error", int'(r_error), err);
        check("rx_packet", int'(rx_packet), pkt_prev);
        eop = 1'b0;
        tick;
        if (err) begin
            check("err_idle", int'(idle), 1);
            check("err_rcving", int'(rcving), 0);
        end else begin
            check("done_rcving", int'(rcving), 1);
            d_edge = 1'b1;
            tick;
            d_edge = 1'b0;
            tick;
            check("j_idle", int'(idle), 1);
            check("j_rcving", int'(rcving), 0);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pkt[$];
        int base, kind, np, fidx;

        rst = 1'b1; d_edge = 1'b0; eop = 1'b0; shift_enable = 1'b0;
        byte_received = 1'b0; rcv_data = 8'h00; fifo_full = 1'b0;
        #12;
        check("rst_idle", int'(idle), 1);
        check("rst_rcving", int'(rcving), 0);
        check("rst_w_enable", int'(w_enable), 0);
        check("rst_r_error", int'(r_error), 0);
        check("rst_rx_packet", int'(rx_packet), 0);
        check("rst_data_ready", int'(rx_data_ready), 0);
        tick;
        rst = 1'b0;
        tick;

        pkt = '{8'h80, 8'hC3, 8'h11, 8'h22, 8'hAB, 8'hCD};
        run_packet(pkt, -1, 1, 3);
        pkt = '{8'h80, 8'hD2};
        run_packet(pkt, -1, 1, 3);
        pkt = '{8'h80, 8'h69, 8'h05, 8'hA8};
        run_packet(pkt, -1, 1, 3);
        pkt = '{8'h81, 8'hC3, 8'h11};
        run_packet(pkt, -1, 1, 3);
        pkt = '{8'h80, 8'hC3, 8'h33, 8'h44};
        run_packet(pkt, -1, 1, 3);
        pkt = '{8'h80, 8'hC4, 8'h11, 8'h22};
        run_packet(pkt, -1, 1, 3);
        pkt = '{8'h80, 8'h4B};
        for (int i = 0; i < 65; i++) pkt.push_back(8'($urandom));
        run_packet(pkt, -1, 1, 2);
        pkt = '{8'h80, 8'hC3, 8'h11, 8'h22, 8'hAB, 8'hCD};
        run_packet(pkt, -1, 8, 8);
        pkt = '{8'h80, 8'hC3, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        run_packet(pkt, 2, 1, 3);

        // Reset in the middle of a DATA0 payload.
        base = wr_q.size();
        start_packet;
        send_byte(8'h80, 2, 1'b0);
        send_byte(8'hC3, 2, 1'b0);
        send_byte(8'h11, 2, 1'b0);
        send_byte(8'h22, 2, 1'b0);
        check("mid_wr_count", wr_q.size() - base, 2);
        check("mid_rcving", int'(rcving), 1);
        check("mid_rx_packet", int'(rx_packet), 3);
        #2 rst = 1'b1;
        #1;
        check("arst_idle", int'(idle), 1);
        check("arst_rcving", int'(rcving), 0);
        check("arst_w_enable", int'(w_enable), 0);
        check("arst_r_error", int'(r_error), 0);
        check("arst_rx_packet", int'(rx_packet), 0);
        check("arst_data_ready", int'(rx_data_ready), 0);
        tick;
        tick;
        rst = 1'b0;
        pkt_prev = 0;
        tick;
        pkt = '{8'h80, 8'h4B, 8'h5A, 8'hA5, 8'h3C};
        run_packet(pkt, -1, 1, 4);

        for (int r = 0; r < 40; r++) begin
            pkt  = '{8'h80};
            fidx = -1;
            kind = $urandom_range(0, 5);
            case (kind)
                0: begin
                    pkt.push_back($urandom_range(0, 1) ? 8'hC3 : 8'h4B);
                    np = $urandom_range(0, 68);
                    for (int i = 0; i < np; i++) pkt.push_back(8'($urandom));
                    if ($urandom_range(0, 3) == 0) fidx = $urandom_range(0, np + 1);
                end
                1: begin
                    pkt.push_back($urandom_range(0, 1) ? 8'hE1 : 8'h69);
                    np = $urandom_range(1, 3);
                    for (int i = 0; i < np; i++) pkt.push_back(8'($urandom));
                end
                2: begin
                    case ($urandom_range(0, 2))
                        0:       pkt.push_back(8'hD2);
                        1:       pkt.push_back(8'h5A);
                        default: pkt.push_back(8'h1E);
                    endcase
                    if ($urandom_range(0, 3) == 0) pkt.push_back(8'($urandom));
                end
                3: begin
                    pkt[0] = 8'($urandom_range(0, 254));
                    if (pkt[0] == 8'h80) pkt[0] = 8'hFF;
                    np = $urandom_range(0, 3);
                    for (int i = 0; i < np; i++) pkt.push_back(8'($urandom));
                end
                4: begin
                    np = $urandom_range(1, 4);
                    for (int i = 0; i < np; i++) pkt.push_back(8'($urandom));
                end
                default: begin
                    if ($urandom_range(0, 1) == 0) pkt = {};
                end
            endcase
            run_packet(pkt, fidx, 1, 8);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
